// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and a start/done handshake.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_src1;
  logic [WIDTH-1:0]     r_src2;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_dbz;

  logic                 w_is_div;
  logic                 w_is_signed;
  logic                 w_s2_zero;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;
  logic [WIDTH:0]       w_msum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_drem;
  logic                 w_dge;
  logic [WIDTH-1:0]     w_dsub;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_is_div    = r_op[1];
  assign w_is_signed = r_op[0];
  assign w_s2_zero   = (r_src2 == '0);

  always_comb begin
    w_mag1     = (w_is_signed && r_src1[WIDTH-1]) ? -r_src1 : r_src1;
    w_mag2     = (w_is_signed && r_src2[WIDTH-1]) ? -r_src2 : r_src2;

    // Multiply step: add multiplicand into the high half, shift right with carry.
    w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
    w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

    // Divide step: partial remainder after the left shift needs WIDTH+1 bits.
    w_drem     = r_acc[2*WIDTH-1:WIDTH-1];
    w_dge      = (w_drem >= {1'b0, r_opnd});
    w_dsub     = w_drem[WIDTH-1:0] - r_opnd;
    w_div_next = {(w_dge ? w_dsub : w_drem[WIDTH-1:0]), r_acc[WIDTH-2:0], w_dge};

    w_prod     = r_neg_res ? -r_acc : r_acc;
    w_quo      = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem      = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = (start && !cancel) ? S_PREP : S_IDLE;
      S_PREP: begin
        if (cancel)                     w_next = S_IDLE;
        else if (w_is_div && w_s2_zero) w_next = S_DONE;
        else                            w_next = S_CALC;
      end
      S_CALC: begin
        if (cancel)                     w_next = S_IDLE;
        else if (r_cnt == CNT_W'(1))    w_next = S_FIX;
      end
      S_FIX:   w_next = cancel ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && !cancel) begin
            r_op   <= op;
            r_src1 <= src1;
            r_src2 <= src2;
          end
        end
        S_PREP: begin
          if (!cancel) begin
            r_neg_res <= w_is_signed && (r_src1[WIDTH-1] ^ r_src2[WIDTH-1]);
            r_neg_rem <= w_is_signed && r_src1[WIDTH-1];
            // Divide: divisor held in r_opnd, dividend shifts through the low half.
            r_opnd    <= w_is_div ? w_mag2 : w_mag1;
            r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            r_cnt     <= CNT_W'(WIDTH);
            if (w_is_div && w_s2_zero) begin
              r_hi  <= r_src1;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (!cancel) begin
            r_acc <= w_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!cancel) begin
            if (w_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign result_hi   = r_hi;
  assign result_lo   = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vectors at WIDTH=32 and a
// randomised WIDTH=8 run against an arithmetic reference model.
module tb_mdu_iter;

  localparam logic [1:0] MULTU = 2'd0;
  localparam logic [1:0] MULT  = 2'd1;
  localparam logic [1:0] DIVU  = 2'd2;
  localparam logic [1:0] DIV   = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, cancel32, busy32, done32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        start8, cancel8, busy8, done8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  mdu_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .src1(a32), .src2(b32),
    .cancel(cancel32), .busy(busy32), .done(done32), .result_hi(hi32),
    .result_lo(lo32), .div_by_zero(dbz32)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .src1(a8), .src2(b8),
    .cancel(cancel8), .busy(busy8), .done(done8), .result_hi(hi8),
    .result_lo(lo8), .div_by_zero(dbz8)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic kick32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0;
    op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
  endtask

  task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    kick32(o, a, b);
    lat = 1;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Reference: plain integer arithmetic, C-style truncating division.
  task automatic ref8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] hi, output logic [7:0] lo, output logic dbz);
    int sa, sb, p, q, r;
    sa = o[0] ? int'($signed(a)) : int'(a);
    sb = o[0] ? int'($signed(b)) : int'(b);
    dbz = 1'b0;
    if (!o[1]) begin
      p  = sa * sb;
      hi = p[15:8];
      lo = p[7:0];
    end else if (b == 8'd0) begin
      hi  = a;
      lo  = 8'hFF;
      dbz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[7:0];
      lo = q[7:0];
    end
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'hFF;
      3:       return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int lat, n, ndone;
    logic [31:0] cap_hi, cap_lo;
    logic [7:0]  ehi, elo;
    logic        edbz;
    logic [1:0]  ro;
    logic [7:0]  ra, rb;

    tbl[0]  = '{MULTU, 32'd3,          32'd5,          32'h0,          32'hF,          1'b0, 35};
    tbl[1]  = '{MULT,  32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   32'hFFFFFFFA,   1'b0, 35};
    tbl[2]  = '{MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   1'b0, 35};
    tbl[3]  = '{DIV,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   1'b0, 35};
    tbl[4]  = '{DIV,   32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000,   1'b0, 35};
    tbl[5]  = '{DIVU,  32'd7,          32'd0,          32'd7,          32'hFFFFFFFF,   1'b1, 2};
    tbl[6]  = '{DIVU,  32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 35};
    tbl[7]  = '{MULT,  32'd7,          32'hFFFFFFFD,   32'hFFFFFFFF,   32'hFFFFFFEB,   1'b0, 35};
    tbl[8]  = '{DIV,   32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   1'b0, 35};
    tbl[9]  = '{DIV,   32'hFFFFFFF8,   32'd0,          32'hFFFFFFF8,   32'hFFFFFFFF,   1'b1, 2};
    tbl[10] = '{MULT,  32'h80000000,   32'h80000000,   32'h40000000,   32'h0,          1'b0, 35};
    tbl[11] = '{DIVU,  32'd5,          32'd10,         32'd5,          32'd0,          1'b0, 35};

    rst = 1'b1;
    start32 = 1'b0; cancel32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; cancel8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy32, 0);
    chk("reset_done", done32, 0);
    chk("reset_hi",   hi32,   0);
    chk("reset_lo",   lo32,   0);
    chk("reset_dbz",  dbz32,  0);
    chk("reset_busy8", busy8, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run32(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_hi", i), hi32, tbl[i].hi);
      chk($sformatf("vec%0d_lo", i), lo32, tbl[i].lo);
      chk($sformatf("vec%0d_dbz", i), dbz32, tbl[i].dbz);
      chk($sformatf("vec%0d_busy_at_done", i), busy32, 0);
    end

    // Reset in the middle of CALC clears everything.
    kick32(MULTU, 32'h1234, 32'h5678);
    repeat (9) @(posedge clk);
    #1;
    chk("midcalc_busy_before_reset", busy32, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_busy", busy32, 0);
    chk("midreset_done", done32, 0);
    chk("midreset_hi",   hi32,   0);
    chk("midreset_lo",   lo32,   0);
    chk("midreset_dbz",  dbz32,  0);
    run32(MULTU, 32'd3, 32'd5, lat);
    chk("postreset_latency", lat, 35);
    chk("postreset_hi", hi32, 32'h0);
    chk("postreset_lo", lo32, 32'hF);

    // Cancel at cycle 10: no done, results unchanged.
    run32(DIVU, 32'd9, 32'd2, lat);
    kick32(DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    cancel32 = 1'b1;
    @(posedge clk); #1;
    cancel32 = 1'b0;
    chk("cancel_busy_drop", busy32, 0);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) n++;
    end
    chk("cancel_no_done", n, 0);
    chk("cancel_hi_kept", hi32, 32'd1);
    chk("cancel_lo_kept", lo32, 32'd4);
    run32(DIVU, 32'd100, 32'd7, lat);
    chk("after_cancel_latency", lat, 35);
    chk("after_cancel_lo", lo32, 32'd14);
    chk("after_cancel_hi", hi32, 32'd2);

    // Cancel in IDLE blocks a simultaneous start.
    @(negedge clk);
    start32 = 1'b1; cancel32 = 1'b1; op32 = MULTU; a32 = 32'd2; b32 = 32'd2;
    @(posedge clk); #1;
    start32 = 1'b0; cancel32 = 1'b0;
    chk("idle_cancel_blocks_start", busy32, 0);

    // Back-to-back with an ignored start while busy.
    kick32(MULTU, 32'd6, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start32 = 1'b1; op32 = MULTU; a32 = 32'd100; b32 = 32'd100;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ndone = done32 ? 1 : 0;
    chk("b2b_first_hi", hi32, 32'd0);
    chk("b2b_first_lo", lo32, 32'd42);
    start32 = 1'b1; op32 = DIVU; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    chk("b2b_second_starts_immediately", busy32, 1);
    cap_hi = '0; cap_lo = '0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done32) begin
        ndone++;
        cap_hi = hi32;
        cap_lo = lo32;
      end
    end
    chk("b2b_done_count", ndone, 2);
    chk("b2b_second_lo", cap_lo, 32'd14);
    chk("b2b_second_hi", cap_hi, 32'd2);

    // WIDTH=8 randomised sweep.
    for (int k = 0; k < 1000; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick8();
      rb = pick8();
      ref8(ro, ra, rb, ehi, elo, edbz);
      run8(ro, ra, rb, lat);
      chk($sformatf("w8_%0d_op%0d_%0h_%0h_latency", k, ro, ra, rb), lat, edbz ? 2 : 11);
      chk($sformatf("w8_%0d_op%0d_%0h_%0h_hi", k, ro, ra, rb), hi8, ehi);
      chk($sformatf("w8_%0d_op%0d_%0h_%0h_lo", k, ro, ra, rb), lo8, elo);
      chk($sformatf("w8_%0d_op%0d_%0h_%0h_dbz", k, ro, ra, rb), dbz8, edbz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
